uart_rx_fifo: RTL

Parametrised, synthesizable UART receiver with a receive FIFO and sticky error flags. It is the successor to the fixed 9600-baud, 8-bit, display-only testbench UART: baud divisor, data width, parity mode and buffer depth are configurable, and received frames are delivered through a ready/valid handshake. It sits inside a user design, fed from a GPIO input such as the management core's UART TX line, so that firmware output can be checked in RTL and on silicon.

---
 rtl/uart_rx_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with a show-ahead receive FIFO and sticky error flags.
// Frames are sampled mid-bit from a synchronized rx line and handed out through ready/valid.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 1042,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   bad_q;
  logic                   push_q;
  logic [DATA_BITS-1:0]   push_data_q;
  logic                   framing_err_q;
  logic                   parity_err_q;

  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic                   rx_prev_q;
  logic                   fall;
  logic                   parity_exp;

  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   overrun_q, overrun_d;
  logic                   pop;
  logic                   full;
  logic                   push_ok;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign fall       = rx_prev_q & ~rx_s_q;
  assign parity_exp = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      bad_q         <= 1'b0;
      push_q        <= 1'b0;
      push_data_q   <= '0;
      framing_err_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      // Clearing comes first so a flag event later in this block takes priority.
      if (err_clr) begin
        framing_err_q <= 1'b0;
        parity_err_q  <= 1'b0;
      end
      if (!en) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fall) begin
              state_q <= S_START;
              cnt_q   <= CW'(CLK_DIV / 2 - 1);
            end
          end
          S_START: begin
            if (cnt_q == '0) begin
              if (!rx_s_q) begin
                state_q   <= S_DATA;
                cnt_q     <= CW'(CLK_DIV - 1);
                bit_idx_q <= '0;
                bad_q     <= 1'b0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_DATA: begin
            if (cnt_q == '0) begin
              shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              cnt_q   <= CW'(CLK_DIV - 1);
              if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                state_q <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_PAR: begin
            if (cnt_q == '0) begin
              if (rx_s_q != parity_exp) begin
                bad_q <= 1'b1;
              end
              cnt_q   <= CW'(CLK_DIV - 1);
              state_q <= S_STOP;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_STOP: begin
            if (cnt_q == '0) begin
              if (rx_s_q) begin
                if (!bad_q) begin
                  push_q      <= 1'b1;
                  push_data_q <= shift_q;
                end else begin
                  parity_err_q <= 1'b1;
                end
                state_q <= S_IDLE;
              end else begin
                framing_err_q <= 1'b1;
                if (bad_q) begin
                  parity_err_q <= 1'b1;
                end
                state_q <= S_WAIT_IDLE;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign count    = wr_ptr_q - rd_ptr_q;
  assign rd_valid = (count != '0);
  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop      = rd_valid & rd_ready;
  assign push_ok  = push_q & (~full | pop);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  // A refused push only raises overrun; stored entries are never touched.
  always_comb begin
    wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
    overrun_d = overrun_q;
    if (err_clr) begin
      overrun_d = 1'b0;
    end
    if (push_q && !push_ok) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
    end
  end

  assign framing_err = framing_err_q;
  assign parity_err  = parity_err_q;
  assign overrun     = overrun_q;

endmodule
